crc_engine_param: RTL and testbench

//  Parametrised CRC generator/checker; successor to the fixed 32-bit/CRC-7 engine.

---
 rtl/crc_engine_param_pkg.sv | 18 +
 rtl/crc_engine_param_if.sv | 24 ++
 rtl/crc_engine_param_step_comb.sv | 24 ++
 rtl/crc_engine_param.sv | 113 +++++++++++
 tb/tb_crc_engine_param.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_engine_param_pkg.sv
// Shared types and helpers for the parametrised CRC engine.
package crc_engine_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/crc_engine_param_if.sv
// Request/result bundle between a bus master (register block) and the CRC engine.
interface crc_engine_param_if #(
  parameter int DATA_W = 40,
  parameter int CRC_W  = 7
);
  logic              start;
  logic              mode_check;
  logic [DATA_W-1:0] data_in;
  logic [CRC_W-1:0]  crc_in;
  logic              busy;
  logic              done;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_ok;

  modport master (
    output start, mode_check, data_in, crc_in,
    input  busy, done, crc_out, crc_ok
  );

  modport slave (
    input  start, mode_check, data_in, crc_in,
    output busy, done, crc_out, crc_ok
  );
endinterface

// File: rtl/crc_engine_param_step_comb.sv
// Combinational CRC update over BITS_PER_CYC message bits, MSB first.
// Plain shift-register form: no augmentation, reflection or final XOR.
module crc_step_comb #(
  parameter int               CRC_W        = 7,
  parameter logic [CRC_W-1:0] POLY         = CRC_W'('h09),
  parameter int               BITS_PER_CYC = 1
) (
  input  logic [CRC_W-1:0]        crc_cur,
  input  logic [BITS_PER_CYC-1:0] bits,
  output logic [CRC_W-1:0]        crc_nxt
);

  // Unrolled bit-serial update; bits[BITS_PER_CYC-1] is consumed first.
  always_comb begin
    logic [CRC_W-1:0] c;
    c = crc_cur;
    for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
      if (c[CRC_W-1] ^ bits[i]) c = {c[CRC_W-2:0], 1'b0} ^ POLY;
      else                      c = {c[CRC_W-2:0], 1'b0};
    end
    crc_nxt = c;
  end

endmodule

// File: rtl/crc_engine_param.sv
// Parametrised CRC generator/checker with start/busy/done handshake.
// RUN spends N = DATA_W/BITS_PER_CYC edges consuming the captured message,
// then one more edge registering crc_out/crc_ok before the single DONE cycle.
module crc_engine_param
  import crc_engine_param_pkg::*;
#(
  parameter int               DATA_W       = 40,
  parameter int               CRC_W        = 7,
  parameter logic [CRC_W-1:0] POLY         = CRC_W'('h09),
  parameter logic [CRC_W-1:0] INIT         = '0,
  parameter int               BITS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  crc_engine_param_if.slave bus
);

  localparam int N     = DATA_W / BITS_PER_CYC;
  localparam int CNT_W = clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

  // Reject configurations the datapath cannot handle.
  if ((DATA_W % BITS_PER_CYC) != 0) begin : g_bad_bpc
    $error("crc_engine_param: BITS_PER_CYC must divide DATA_W");
  end
  if ((CRC_W < 2) || (CRC_W > 32)) begin : g_bad_crcw
    $error("crc_engine_param: CRC_W must be in 2..32");
  end

  crc_state_e              r_state;
  crc_state_e              w_state_nxt;
  logic [DATA_W-1:0]       r_data;
  logic [CRC_W-1:0]        r_crc_in;
  logic                    r_mode;
  logic [CRC_W-1:0]        r_crc;
  logic [CNT_W-1:0]        r_cnt;
  logic [CRC_W-1:0]        r_crc_out;
  logic                    r_crc_ok;
  logic [BITS_PER_CYC-1:0] w_bits;
  logic [CRC_W-1:0]        w_crc_nxt;

  // Next message chunk always sits at the top of the capture register.
  assign w_bits = r_data[DATA_W-1 -: BITS_PER_CYC];

  crc_step_comb #(
    .CRC_W        (CRC_W),
    .POLY         (POLY),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_step (
    .crc_cur (r_crc),
    .bits    (w_bits),
    .crc_nxt (w_crc_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture, shift/update and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_crc_in  <= '0;
      r_mode    <= 1'b0;
      r_crc     <= '0;
      r_cnt     <= '0;
      r_crc_out <= '0;
      r_crc_ok  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_data   <= bus.data_in;
            r_crc_in <= bus.crc_in;
            r_mode   <= bus.mode_check;
            r_crc    <= INIT;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          if (r_cnt != CNT_LAST) begin
            r_crc  <= w_crc_nxt;
            r_data <= r_data << BITS_PER_CYC;
            r_cnt  <= r_cnt + CNT_W'(1);
          end else begin
            r_crc_out <= r_crc;
            r_crc_ok  <= r_mode && (r_crc == r_crc_in);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.crc_out = r_crc_out;
  assign bus.crc_ok  = r_crc_ok;

endmodule

// File: tb/tb_crc_engine_param.sv
// Bench for crc_engine_param: three configurations (CRC-7/1b, CRC-16/4b with
// non-zero seed, CRC-8/8b) checked against a polynomial long-division model.
module tb_crc_engine_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  crc_engine_param_if #(.DATA_W(40), .CRC_W(7))  b0();
  crc_engine_param_if #(.DATA_W(40), .CRC_W(16)) b1();
  crc_engine_param_if #(.DATA_W(72), .CRC_W(8))  b2();

  crc_engine_param #(.DATA_W(40), .CRC_W(7), .POLY(7'h09), .INIT(7'h00), .BITS_PER_CYC(1))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  crc_engine_param #(.DATA_W(40), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .BITS_PER_CYC(4))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  crc_engine_param #(.DATA_W(72), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .BITS_PER_CYC(8))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // CRC as remainder of M(x)*x^cw + S(x)*x^dw divided by the full generator.
  function automatic logic [31:0] model(input logic [127:0] d, input int dw, input int cw,
                                        input logic [31:0] poly, input logic [31:0] init);
    logic [191:0] v, g;
    logic [31:0]  mask;
    v = (192'(d) << cw) ^ (192'(init) << dw);
    g = (192'(1) << cw) | 192'(poly);
    for (int i = dw + cw - 1; i >= cw; i--)
      if (v[i]) v = v ^ (g << (i - cw));
    mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return v[31:0] & mask;
  endfunction

  // done must be a single cycle with busy high, and IDLE (busy=0) must follow it.
  logic pd0, pd1, pd2;
  always @(negedge clk) begin
    if (b0.done === 1'b1) begin
      checks++;
      if (pd0 === 1'b1 || b0.busy !== 1'b1) begin
        errors++; $display("FAIL mon_done0 prev_done=%b busy=%b exp prev_done=0 busy=1", pd0, b0.busy);
      end
    end
    if (b1.done === 1'b1) begin
      checks++;
      if (pd1 === 1'b1 || b1.busy !== 1'b1) begin
        errors++; $display("FAIL mon_done1 prev_done=%b busy=%b exp prev_done=0 busy=1", pd1, b1.busy);
      end
    end
    if (b2.done === 1'b1) begin
      checks++;
      if (pd2 === 1'b1 || b2.busy !== 1'b1) begin
        errors++; $display("FAIL mon_done2 prev_done=%b busy=%b exp prev_done=0 busy=1", pd2, b2.busy);
      end
    end
    if (rst === 1'b1 && pd0 === 1'b1 && b0.busy !== 1'b0) begin
      errors++; $display("FAIL mon_idle0 busy=%b exp 0 after done", b0.busy);
    end
    if (rst === 1'b1 && pd1 === 1'b1 && b1.busy !== 1'b0) begin
      errors++; $display("FAIL mon_idle1 busy=%b exp 0 after done", b1.busy);
    end
    if (rst === 1'b1 && pd2 === 1'b1 && b2.busy !== 1'b0) begin
      errors++; $display("FAIL mon_idle2 busy=%b exp 0 after done", b2.busy);
    end
    pd0 <= b0.done;
    pd1 <= b1.done;
    pd2 <= b2.done;
  end

  // One transaction per DUT; lat = edges after the sampling edge until done is seen.
  // Inputs are scrambled right after the sampling edge to show only captured copies matter.
  task automatic run0(input logic [39:0] d, input logic m, input logic [6:0] ci,
                      output int lat, output logic [6:0] co, output logic ok);
    @(negedge clk);
    b0.data_in = d; b0.mode_check = m; b0.crc_in = ci; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0; b0.data_in = ~d; b0.crc_in = ~ci; b0.mode_check = ~m;
    lat = 0;
    while (b0.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    co = b0.crc_out; ok = b0.crc_ok;
    @(posedge clk); #1;
  endtask

  task automatic run1(input logic [39:0] d, input logic m, input logic [15:0] ci,
                      output int lat, output logic [15:0] co, output logic ok);
    @(negedge clk);
    b1.data_in = d; b1.mode_check = m; b1.crc_in = ci; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.data_in = ~d; b1.crc_in = ~ci; b1.mode_check = ~m;
    lat = 0;
    while (b1.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    co = b1.crc_out; ok = b1.crc_ok;
    @(posedge clk); #1;
  endtask

  task automatic run2(input logic [71:0] d, input logic m, input logic [7:0] ci,
                      output int lat, output logic [7:0] co, output logic ok);
    @(negedge clk);
    b2.data_in = d; b2.mode_check = m; b2.crc_in = ci; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0; b2.data_in = ~d; b2.crc_in = ~ci; b2.mode_check = ~m;
    lat = 0;
    while (b2.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    co = b2.crc_out; ok = b2.crc_ok;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", b0.busy); end
    checks++; if (b0.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", b0.done); end
    checks++; if (b0.crc_out !== 7'h00) begin errors++; $display("FAIL rst_crc_out got=%h exp=00", b0.crc_out); end
    checks++; if (b0.crc_ok !== 1'b0) begin errors++; $display("FAIL rst_crc_ok got=%b exp=0", b0.crc_ok); end
    checks++; if (b2.busy !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy12 got=%b%b exp=00", b1.busy, b2.busy); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cmd0();
    int lat; logic [6:0] co; logic ok;
    run0(40'h40_0000_0000, 1'b0, 7'h00, lat, co, ok);
    checks++; if (lat !== 41) begin errors++; $display("FAIL cmd0_latency got=%0d exp=41", lat); end
    checks++; if (co !== 7'h4A) begin errors++; $display("FAIL cmd0_crc got=%h exp=4a", co); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL cmd0_ok got=%b exp=0", ok); end
  endtask

  task automatic test_cmd8();
    int lat; logic [6:0] co; logic ok;
    run0(40'h48_0000_01AA, 1'b0, 7'h43, lat, co, ok);
    checks++; if (co !== 7'h43) begin errors++; $display("FAIL cmd8_gen_crc got=%h exp=43", co); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL cmd8_gen_ok got=%b exp=0", ok); end
    run0(40'h48_0000_01AA, 1'b1, 7'h43, lat, co, ok);
    checks++; if (co !== 7'h43 || ok !== 1'b1) begin errors++; $display("FAIL cmd8_chk_good got=%h/%b exp=43/1", co, ok); end
    run0(40'h48_0000_01AA, 1'b1, 7'h42, lat, co, ok);
    checks++; if (co !== 7'h43 || ok !== 1'b0) begin errors++; $display("FAIL cmd8_chk_bad got=%h/%b exp=43/0", co, ok); end
  endtask

  task automatic test_crc8();
    int lat; logic [7:0] co; logic ok; logic [71:0] s;
    s = "123456789";
    run2(s, 1'b0, 8'h00, lat, co, ok);
    checks++; if (lat !== 10) begin errors++; $display("FAIL crc8_latency got=%0d exp=10", lat); end
    checks++; if (co !== 8'hF4) begin errors++; $display("FAIL crc8_crc got=%h exp=f4", co); end
  endtask

  // start held high across the whole run; data_in toggled every RUN cycle.
  task automatic test_handshake();
    logic [39:0] d; logic [31:0] e; logic [6:0] first; int dones;
    d = 40'({$urandom(), $urandom()});
    e = model(128'(d), 40, 7, 32'h09, 32'h0);
    dones = 0; first = '0;
    @(negedge clk);
    b0.data_in = d; b0.mode_check = 1'b0; b0.start = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(posedge clk); #1;
      if (b0.done === 1'b1) begin
        dones++;
        if (dones == 1) begin first = b0.crc_out; b0.start = 1'b0; end
      end else if (dones == 0) begin
        b0.data_in = ~b0.data_in;
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL hs_done_count got=%0d exp=1", dones); end
    checks++; if (first !== e[6:0]) begin errors++; $display("FAIL hs_crc got=%h exp=%h", first, e[6:0]); end
    checks++; if (b0.crc_out !== e[6:0]) begin errors++; $display("FAIL hs_hold got=%h exp=%h", b0.crc_out, e[6:0]); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [6:0] co; logic ok;
    run0(40'h48_0000_01AA, 1'b1, 7'h43, lat, co, ok);   // leave crc_out/crc_ok non-zero
    @(negedge clk);
    b0.data_in = 40'h40_0000_0000; b0.mode_check = 1'b0; b0.start = 1'b1;
    @(posedge clk); #1 b0.start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", b0.busy); end
    checks++; if (b0.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b exp=0", b0.done); end
    checks++; if (b0.crc_out !== 7'h00) begin errors++; $display("FAIL mid_rst_crc_out got=%h exp=00", b0.crc_out); end
    checks++; if (b0.crc_ok !== 1'b0) begin errors++; $display("FAIL mid_rst_crc_ok got=%b exp=0", b0.crc_ok); end
    checks++; if (b2.crc_out !== 8'h00) begin errors++; $display("FAIL mid_rst_crc8_out got=%h exp=00", b2.crc_out); end
    @(negedge clk); rst = 1'b1;
    run0(40'h40_0000_0000, 1'b0, 7'h00, lat, co, ok);
    checks++; if (co !== 7'h4A || lat !== 41) begin errors++; $display("FAIL post_rst_cmd0 got=%h/%0d exp=4a/41", co, lat); end
  endtask

  task automatic rand0();
    logic [39:0] d; logic [6:0] ci, co; logic m, ok; logic [31:0] e; int lat;
    for (int n = 0; n < 1000; n++) begin
      d = 40'({$urandom(), $urandom()});
      m = 1'($urandom_range(0, 1));
      e = model(128'(d), 40, 7, 32'h09, 32'h0);
      ci = ($urandom_range(0, 1) == 1) ? e[6:0] : 7'($urandom());
      run0(d, m, ci, lat, co, ok);
      checks++; if (lat !== 41) begin errors++; $display("FAIL rnd0_lat got=%0d exp=41", lat); end
      checks++; if (co !== e[6:0]) begin errors++; $display("FAIL rnd0_crc d=%h got=%h exp=%h", d, co, e[6:0]); end
      checks++; if (ok !== (m && ci == e[6:0])) begin errors++; $display("FAIL rnd0_ok got=%b exp=%b", ok, m && ci == e[6:0]); end
    end
  endtask

  task automatic rand1();
    logic [39:0] d; logic [15:0] ci, co; logic m, ok; logic [31:0] e; int lat;
    for (int n = 0; n < 1000; n++) begin
      d = 40'({$urandom(), $urandom()});
      m = 1'($urandom_range(0, 1));
      e = model(128'(d), 40, 16, 32'h1021, 32'hFFFF);
      ci = ($urandom_range(0, 1) == 1) ? e[15:0] : 16'($urandom());
      run1(d, m, ci, lat, co, ok);
      checks++; if (lat !== 11) begin errors++; $display("FAIL rnd1_lat got=%0d exp=11", lat); end
      checks++; if (co !== e[15:0]) begin errors++; $display("FAIL rnd1_crc d=%h got=%h exp=%h", d, co, e[15:0]); end
      checks++; if (ok !== (m && ci == e[15:0])) begin errors++; $display("FAIL rnd1_ok got=%b exp=%b", ok, m && ci == e[15:0]); end
    end
  endtask

  task automatic rand2();
    logic [71:0] d; logic [7:0] ci, co; logic m, ok; logic [31:0] e; int lat;
    for (int n = 0; n < 1000; n++) begin
      d = 72'({$urandom(), $urandom(), $urandom()});
      m = 1'($urandom_range(0, 1));
      e = model(128'(d), 72, 8, 32'h07, 32'h0);
      ci = ($urandom_range(0, 1) == 1) ? e[7:0] : 8'($urandom());
      run2(d, m, ci, lat, co, ok);
      checks++; if (lat !== 10) begin errors++; $display("FAIL rnd2_lat got=%0d exp=10", lat); end
      checks++; if (co !== e[7:0]) begin errors++; $display("FAIL rnd2_crc d=%h got=%h exp=%h", d, co, e[7:0]); end
      checks++; if (ok !== (m && ci == e[7:0])) begin errors++; $display("FAIL rnd2_ok got=%b exp=%b", ok, m && ci == e[7:0]); end
    end
  endtask

  task automatic test_random();
    fork
      rand0();
      rand1();
      rand2();
    join
  endtask

  initial begin
    b0.start = 1'b0; b0.mode_check = 1'b0; b0.data_in = '0; b0.crc_in = '0;
    b1.start = 1'b0; b1.mode_check = 1'b0; b1.data_in = '0; b1.crc_in = '0;
    b2.start = 1'b0; b2.mode_check = 1'b0; b2.data_in = '0; b2.crc_in = '0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc8();
    test_handshake();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
